// File: rtl/logic_unit_pkg.sv
// Shared encodings for the ALU32 logic group: bitwise op codes and arbiter FSM states.
// Imported by logic_op32 and logic_unit_arbiter.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op32.sv
// Purely combinational 32-bit bitwise unit: AND / OR / XOR / NOR selected by Op.
// Zero latency; no flow control.
module logic_op32
    import logic_unit_pkg::*;
(
    input  logic [1:0]  Op,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    output logic [31:0] Out
);

    always_comb begin
        Out = '0;
        case (Op)
            OP_AND:  Out = In1 & In2;
            OP_OR:   Out = In1 | In2;
            OP_XOR:  Out = In1 ^ In2;
            OP_NOR:  Out = ~(In1 | In2);
            default: Out = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_op32 among NREQ requesters; result 2 cycles after grant.
// Single request in flight: Req_Ready is held low until the response is taken by Rsp_Ready.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NREQ-1:0]     Req_Valid,
    output logic [NREQ-1:0]     Req_Ready,
    input  logic [2*NREQ-1:0]   Req_Op,
    input  logic [32*NREQ-1:0]  Req_A,
    input  logic [32*NREQ-1:0]  Req_B,
    output logic                Rsp_Valid,
    input  logic                Rsp_Ready,
    output logic [31:0]         Rsp_Data,
    output logic [IDW-1:0]      Rsp_Id,
    output logic                Busy
);

    state_t          state_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q;
    logic [1:0]      op_q;
    logic [31:0]     a_q, b_q;
    logic            rsp_vld_q;
    logic [31:0]     rsp_dat_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            win_vld;
    logic [IDW-1:0]  win_id;
    logic            req_hs;
    logic [31:0]     lu_out;
    int              j;

    // Scan from the highest offset down so the nearest valid requester at or after Ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (Req_Valid[j]) begin
                win_vld = 1'b1;
                win_id  = IDW'(j);
            end
        end
    end

    assign req_hs    = Rst_n && (state_q == ST_IDLE) && win_vld;
    assign Req_Ready = req_hs ? (NREQ'(1) << win_id) : '0;
    assign ptr_d     = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

    logic_op32 u_logic_op32 (
        .Op  (op_q),
        .In1 (a_q),
        .In2 (b_q),
        .Out (lu_out)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        op_q    <= Req_Op[2*int'(win_id) +: 2];
                        a_q     <= Req_A[32*int'(win_id) +: 32];
                        b_q     <= Req_B[32*int'(win_id) +: 32];
                        id_q    <= win_id;
                        ptr_q   <= ptr_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_dat_q <= lu_out;
                    rsp_id_q  <= id_q;
                    rsp_vld_q <= 1'b1;
                    state_q   <= ST_RESP;
                end
                ST_RESP: begin
                    if (Rsp_Ready) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Rsp_Valid = rsp_vld_q;
    assign Rsp_Data  = rsp_dat_q;
    assign Rsp_Id    = rsp_id_q;
    assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: driver pushes expected {id,data} at each grant,
// a negedge monitor pops and compares on every accepted response.
module tb_logic_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              Clk;
    logic              Rst_n;
    logic [NREQ-1:0]   Req_Valid;
    logic [NREQ-1:0]   Req_Ready;
    logic [2*NREQ-1:0] Req_Op;
    logic [32*NREQ-1:0] Req_A;
    logic [32*NREQ-1:0] Req_B;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic [31:0]       Rsp_Data;
    logic [IDW-1:0]    Rsp_Id;
    logic              Busy;

    logic [1:0]  op_t [NREQ];
    logic [31:0] a_t  [NREQ];
    logic [31:0] b_t  [NREQ];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [33:0] exp_q[$];
    int          lat_q[$];
    logic        prev_vld = 1'b0;
    logic [33:0] mon_e;
    int          mon_h;

    logic [31:0] rr_dat [5];
    logic [3:0]  rr_rdy [5];
    logic [31:0] ops_dat [4];
    int          gc, gc_prev;

    logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_Op    (Req_Op),
        .Req_A     (Req_A),
        .Req_B     (Req_B),
        .Rsp_Valid (Rsp_Valid),
        .Rsp_Ready (Rsp_Ready),
        .Rsp_Data  (Rsp_Data),
        .Rsp_Id    (Rsp_Id),
        .Busy      (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc++;

    always_comb begin
        Req_Op = '0;
        Req_A  = '0;
        Req_B  = '0;
        for (int i = 0; i < NREQ; i++) begin
            Req_Op[2*i +: 2]  = op_t[i];
            Req_A[32*i +: 32] = a_t[i];
            Req_B[32*i +: 32] = b_t[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: response rise time against grant time, and data/id on every accepted response.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Rsp_Valid && !prev_vld) begin
                if (lat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_rise unexpected response at cycle %0d", cyc);
                end else begin
                    mon_h = lat_q.pop_front();
                    chk("latency_cycle", cyc, mon_h + 2);
                end
            end
            if (Rsp_Valid && Rsp_Ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_accept unexpected response data %h id %0d", Rsp_Data, Rsp_Id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", Rsp_Data, mon_e[31:0]);
                    chk("rsp_id", 32'(Rsp_Id), 32'(mon_e[33:32]));
                end
            end
        end
        prev_vld = Rsp_Valid;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_grant(output logic [3:0] rdy, output int gcyc);
        rdy  = '0;
        gcyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (Req_Ready != 0) begin
                rdy  = Req_Ready;
                gcyc = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL grant_timeout no Req_Ready within 40 cycles (Req_Valid %b)", Req_Valid);
    endtask

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Waits for a grant, checks which requester got it, and queues the expected response.
    task automatic grant(input logic [3:0] exp_rdy, input logic [31:0] exp_dat, output int gcyc);
        logic [3:0] r;
        wait_grant(r, gcyc);
        chk("grant_onehot", 32'(r), 32'(exp_rdy));
        if (r != 0) begin
            exp_q.push_back({enc(exp_rdy), exp_dat});
            lat_q.push_back(gcyc);
        end
    endtask

    initial begin
        rr_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat  = '{32'h000000FF, 32'h010000FF, 32'h020000FF, 32'h030000FF, 32'h000000FF};
        ops_dat = '{32'h0000A5A5, 32'hA5A5FFFF, 32'hA5A55A5A, 32'h5A5A0000};
        for (int i = 0; i < NREQ; i++) begin
            op_t[i] = 2'b01;
            a_t[i]  = {8'(i), 24'h0};
            b_t[i]  = 32'h000000FF;
        end

        // Reset state with every requester asking.
        Rst_n     = 1'b0;
        Req_Valid = 4'b1111;
        Rsp_Ready = 1'b1;
        #12;
        chk("rst_req_ready", 32'(Req_Ready), 0);
        chk("rst_rsp_valid", 32'(Rsp_Valid), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_rsp_data", Rsp_Data, 0);
        chk("rst_rsp_id", 32'(Rsp_Id), 0);
        Req_Valid = '0;
        step();
        Rst_n = 1'b1;
        step();

        // Round-robin with all four held valid: ids 0,1,2,3,0 every 3 cycles.
        Req_Valid = 4'b1111;
        gc_prev   = 0;
        for (int k = 0; k < 5; k++) begin
            grant(rr_rdy[k], rr_dat[k], gc);
            if (k > 0) chk("rr_interval", gc - gc_prev, 3);
            gc_prev = gc;
        end
        step();
        Req_Valid = '0;
        repeat (3) step();

        // Single XOR from requester 2.
        op_t[2] = 2'b10; a_t[2] = 32'hFFFF0000; b_t[2] = 32'h0F0F0F0F;
        Req_Valid = 4'b0100;
        grant(4'b0100, 32'hF0F00F0F, gc);
        step();
        Req_Valid = '0;
        repeat (3) step();

        // All four ops from requester 0.
        a_t[0] = 32'hA5A5A5A5; b_t[0] = 32'h0000FFFF;
        for (int op = 0; op < 4; op++) begin
            op_t[0]   = 2'(op);
            Req_Valid = 4'b0001;
            grant(4'b0001, ops_dat[op], gc);
            step();
            Req_Valid = '0;
            repeat (3) step();
        end

        // Backpressure: response held 5 cycles, no new grants while others wait.
        op_t[1] = 2'b00; a_t[1] = 32'hFFFFFFFF; b_t[1] = 32'h12345678;
        Rsp_Ready = 1'b0;
        Req_Valid = 4'b0010;
        grant(4'b0010, 32'h12345678, gc);
        step();
        Req_Valid = 4'b1111;
        @(negedge Clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            chk("bp_valid", 32'(Rsp_Valid), 1);
            chk("bp_data", Rsp_Data, 32'h12345678);
            chk("bp_id", 32'(Rsp_Id), 1);
            chk("bp_req_ready", 32'(Req_Ready), 0);
            chk("bp_busy", 32'(Busy), 1);
        end
        step();
        Req_Valid = '0;
        Rsp_Ready = 1'b1;
        @(negedge Clk);
        chk("bp_accept_cycle_valid", 32'(Rsp_Valid), 1);
        @(negedge Clk);
        chk("bp_done_valid", 32'(Rsp_Valid), 0);
        chk("bp_done_busy", 32'(Busy), 0);
        step();

        // Pointer skip: grant 1, then only 0 valid, then 0 and 3 valid -> 3.
        op_t[1] = 2'b01; a_t[1] = 32'hF0000000; b_t[1] = 32'h0000000F;
        op_t[0] = 2'b11; a_t[0] = 32'h00000000; b_t[0] = 32'hFFFF0000;
        op_t[3] = 2'b10; a_t[3] = 32'h12345678; b_t[3] = 32'hFFFFFFFF;
        Req_Valid = 4'b0010;
        grant(4'b0010, 32'hF000000F, gc);
        step(); Req_Valid = '0; repeat (3) step();
        Req_Valid = 4'b0001;
        grant(4'b0001, 32'h0000FFFF, gc);
        step(); Req_Valid = '0; repeat (3) step();
        Req_Valid = 4'b1001;
        grant(4'b1000, 32'hEDCBA987, gc);
        step(); Req_Valid = '0; repeat (3) step();

        // Reset during EXEC: result discarded, pointer back to 0.
        Req_Valid = 4'b1111;
        begin
            logic [3:0] r;
            wait_grant(r, gc);
            chk("pre_reset_grant", 32'(r), 32'h1);
        end
        step();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(Rsp_Valid), 0);
        chk("mid_rst_req_ready", 32'(Req_Ready), 0);
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_rsp_data", Rsp_Data, 0);
        chk("mid_rst_rsp_id", 32'(Rsp_Id), 0);
        step();
        step();
        Rst_n = 1'b1;
        grant(4'b0001, 32'h0000FFFF, gc);
        step();
        Req_Valid = '0;

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        repeat (2) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
